pipeline_controller: RTL and testbench
======================================

# pipeline_controller

Central stall/flush sequencer for the five-stage core. It merges the decode-stage register-file hazard, multi-cycle execute-unit busy (AI/crypto), data-memory wait and branch mispredict into per-stage stall and flush controls. It drives the decode stage's `stall_decode_stage_i`/`flush_decode_stage_i` and the equivalent controls of fetch, execute and memory. It also defers a mispredict flush that arrives during a memory wait and replays it when the wait ends.

## Interface
- `FLUSH_CYCLES`, default 1: cycles that fetch/decode flush stays asserted per accepted mispredict; legal range 1..15.
- `clk_i` in 1: core clock.
- `rst_i` in 1: reset, asynchronous, active-low.
- `en_stall_decode_stage_i` in 1: register-file hazard from decode (decode inserts its own bubble).
- `exe_busy_i` in 1: multi-cycle execute unit not finished.
- `mem_busy_i` in 1: data memory access outstanding.
- `branch_mispredict_i` in 1: execute-stage mispredict, level-held while execute is held.
- `stall_fetch_o` out 1: hold fetch PC/instruction register.
- `stall_decode_stage_o` out 1: hold decode output register.
- `stall_execute_o` out 1: hold execute output register.
- `stall_memory_o` out 1: hold memory output register.
- `flush_fetch_o` out 1: squash the fetched instruction.
- `flush_decode_stage_o` out 1: force NOP into decode.
- `flush_pending_o` out 1: a mispredict is latched awaiting memory release.

## Operation
- States:
  - FLUSH: counter `cnt` (4 bit) running.
  - RUN
  - MEM_HOLD: mispredict pending.
- Base stall priority, evaluated combinationally every cycle:
  - `mem_busy_i`=1: all four stalls = 1.
  - else `exe_busy_i`=1: fetch, decode and execute stalls = 1; memory = 0, so memory takes a bubble.
  - else `en_stall_decode_stage_i`=1: `stall_fetch_o`=1, all other stalls = 0.
  - else: all stalls = 0.
- Flush term, `fl` = (state==FLUSH) | (`branch_mispredict_i` & !`mem_busy_i` & state==RUN) | (state==MEM_HOLD & !`mem_busy_i`).
  - `flush_fetch_o` = `flush_decode_stage_o` = `fl`.
  - When `fl`=1, `stall_fetch_o` and `stall_decode_stage_o` are forced to 0 (flush overrides stall).
  - Execute and memory stalls still follow the base priority.
- RUN transitions:
  - Mispredict with `mem_busy_i`=0: flush this cycle. If `FLUSH_CYCLES`>1, go to FLUSH with `cnt`=`FLUSH_CYCLES`-1; otherwise stay in RUN.
  - Mispredict with `mem_busy_i`=1: go to MEM_HOLD. No flush this cycle.
- MEM_HOLD:
  - `flush_pending_o`=1.
  - Further mispredict assertions are ignored; there is only a single pending slot.
  - On the first cycle with `mem_busy_i`=0: flush that cycle, then follow the same FLUSH/RUN rule as RUN.
- FLUSH:
  - `cnt` decrements each cycle.
  - At `cnt`==1, return to RUN next cycle.
  - Mispredicts are ignored, since the younger instructions are already being squashed.
  - `mem_busy_i` does not pause the counter.

## Timing
- Stall and flush outputs are combinational from the inputs and the registered state; there is zero-cycle latency from the inputs.
- The state and `cnt` registers update on the rising edge of `clk_i`.
- Async reset (`rst_i`=0):
  - State = FLUSH, `cnt`=`FLUSH_CYCLES`, pending cleared.
  - Outputs while in reset: `flush_fetch_o`=`flush_decode_stage_o`=1, `flush_pending_o`=0, all stalls = 0 (with inputs low).
  - After release, the flush lasts exactly `FLUSH_CYCLES` cycles, then the block enters RUN.
- Reset asserted in MEM_HOLD or FLUSH drops the pending mispredict and restarts the reset flush.
- Mispredict and `mem_busy_i` falling in the same cycle: the flush is taken that cycle and is not deferred.
- `exe_busy_i` together with `en_stall_decode_stage_i`: the exe rule wins, so decode is held rather than bubbled.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: adds two output ports.
  - `perf_stall_cycles_o` out 32: counts cycles with `stall_fetch_o`=1.
  - `perf_flush_count_o` out 16: counts accepted mispredicts, including deferred ones, each counted once.
  - Both counters saturate at all-ones and reset to 0.
- `PIPE_CTRL_PERF_EN` undefined: neither port nor counter exists; behaviour is otherwise identical.

## Test plan
- Reset release, `FLUSH_CYCLES`=2 → flushes = 1 for cycles 0–1 after release; cycle 2 all outputs 0, state RUN.
- `en_stall_decode_stage_i`=1 for 3 cycles → `stall_fetch_o`=1 and `stall_decode_stage_o`=0 for exactly those 3 cycles.
- `exe_busy_i`=1 for 4 cycles with `en_stall_decode_stage_i`=1 → fetch/decode/execute stalls = 1 and `stall_memory_o`=0 for 4 cycles.
- `mem_busy_i`=1 for cycles 0–5 with mispredict held cycles 2–5 → `flush_pending_o`=1 cycles 3–5 (and while mem stays busy); flush = 1 only in cycle 6, when `mem_busy_i`=0.
- Mispredict pulse in RUN with `FLUSH_CYCLES`=3 → flush = 1 for the pulse cycle plus 2 more; a second pulse during that window causes no extension.
- `rst_i` pulled low mid-MEM_HOLD → `flush_pending_o` drops to 0 immediately; after release, only the reset flush occurs. With `PIPE_CTRL_PERF_EN` defined, 3 mispredicts → `perf_flush_count_o`=3.

Source files
------------

// File: rtl/pipeline_controller.sv
// ---------------------------------------------------------------------------
// pipeline_controller
//
// Central stall/flush sequencer for the five-stage core. Merges the decode
// register-file hazard, multi-cycle execute busy, data-memory wait and branch
// mispredict into per-stage stall and flush controls. A mispredict that
// arrives while memory is busy is latched (single slot) and replayed as a
// flush on the first cycle memory is released.
//
// Parameters:
//   FLUSH_CYCLES            cycles fetch/decode flush is held per accepted
//                           mispredict (and after reset), legal 1..15
//
// Ports:
//   clk_i                   core clock
//   rst_i                   asynchronous reset, active low
//   en_stall_decode_stage_i register-file hazard (decode bubbles itself)
//   exe_busy_i              multi-cycle execute unit not finished
//   mem_busy_i              data memory access outstanding
//   branch_mispredict_i     execute-stage mispredict (level, held with execute)
//   stall_fetch_o           hold fetch PC / instruction register
//   stall_decode_stage_o    hold decode output register
//   stall_execute_o         hold execute output register
//   stall_memory_o          hold memory output register
//   flush_fetch_o           squash the fetched instruction
//   flush_decode_stage_o    force NOP into decode
//   flush_pending_o         mispredict latched, awaiting memory release
//
// Optional build macro PIPE_CTRL_PERF_EN adds:
//   perf_stall_cycles_o     [31:0] cycles with stall_fetch_o high (saturating)
//   perf_flush_count_o      [15:0] accepted mispredicts (saturating)
// ---------------------------------------------------------------------------
module pipeline_controller #(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_stall_decode_stage_i,
    input  logic        exe_busy_i,
    input  logic        mem_busy_i,
    input  logic        branch_mispredict_i,
    output logic        stall_fetch_o,
    output logic        stall_decode_stage_o,
    output logic        stall_execute_o,
    output logic        stall_memory_o,
    output logic        flush_fetch_o,
    output logic        flush_decode_stage_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0] perf_stall_cycles_o,
    output logic [15:0] perf_flush_count_o,
`endif
    output logic        flush_pending_o
);

    // State encodings kept as plain constants for compatibility with the
    // existing netlist/debug scripts.
    localparam logic [1:0] ST_FLUSH    = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_MEM_HOLD = 2'd2;

    // Counter load after reset, and reload after the first flush cycle of a
    // mispredict (that first cycle is taken combinationally in RUN/MEM_HOLD).
    localparam logic [3:0] FLUSH_LOAD   = 4'(FLUSH_CYCLES);
    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       fl;

    // -----------------------------------------------------------------------
    // Next-state and flush term
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fl      = 1'b0;

        case (state_q)
            ST_FLUSH: begin
                // Mispredicts are ignored here and memory waits do not pause
                // the count: everything younger is already being squashed.
                fl = 1'b1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_RUN: begin
                if (branch_mispredict_i) begin
                    if (mem_busy_i) begin
                        state_d = ST_MEM_HOLD;
                    end else begin
                        fl = 1'b1;
                        if (MULTI_FLUSH) begin
                            state_d = ST_FLUSH;
                            cnt_d   = FLUSH_RELOAD;
                        end
                    end
                end
            end

            ST_MEM_HOLD: begin
                // Single pending slot: further mispredicts are not recorded.
                if (!mem_busy_i) begin
                    fl = 1'b1;
                    if (MULTI_FLUSH) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_RELOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_FLUSH;
            cnt_q   <= FLUSH_LOAD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Stall priority: memory > execute > decode hazard. A flush overrides the
    // fetch/decode holds so the squashed slots actually advance; execute and
    // memory keep following the base priority.
    // -----------------------------------------------------------------------
    always_comb begin
        stall_fetch_o        = 1'b0;
        stall_decode_stage_o = 1'b0;
        stall_execute_o      = 1'b0;
        stall_memory_o       = 1'b0;

        if (mem_busy_i) begin
            stall_fetch_o        = 1'b1;
            stall_decode_stage_o = 1'b1;
            stall_execute_o      = 1'b1;
            stall_memory_o       = 1'b1;
        end else if (exe_busy_i) begin
            // Memory takes a bubble; decode is held, not bubbled.
            stall_fetch_o        = 1'b1;
            stall_decode_stage_o = 1'b1;
            stall_execute_o      = 1'b1;
        end else if (en_stall_decode_stage_i) begin
            stall_fetch_o = 1'b1;
        end

        if (fl) begin
            stall_fetch_o        = 1'b0;
            stall_decode_stage_o = 1'b0;
        end
    end

    assign flush_fetch_o        = fl;
    assign flush_decode_stage_o = fl;
    assign flush_pending_o      = (state_q == ST_MEM_HOLD);

`ifdef PIPE_CTRL_PERF_EN
    // -----------------------------------------------------------------------
    // Performance counters. A mispredict is counted when RUN accepts it,
    // whether it flushes at once or is deferred, so a replay is not counted
    // a second time.
    // -----------------------------------------------------------------------
    logic        accept;
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    assign accept = (state_q == ST_RUN) && branch_mispredict_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_fetch_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (accept && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign perf_stall_cycles_o = stall_cnt_q;
    assign perf_flush_count_o  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// ---------------------------------------------------------------------------
// Testbench for pipeline_controller. Three instances (FLUSH_CYCLES = 1, 2, 3)
// share one set of inputs; each instance's outputs are packed as
// {stall_fetch, stall_decode, stall_execute, stall_memory,
//  flush_fetch, flush_decode, flush_pending}.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_pipeline_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i;
    logic en_stall;
    logic exe_busy;
    logic mem_busy;
    logic mispredict;

    wire [6:0] o1;
    wire [6:0] o2;
    wire [6:0] o3;

`ifdef PIPE_CTRL_PERF_EN
    wire [31:0] ps1, ps2, ps3;
    wire [15:0] pf1, pf2, pf3;
`endif

    int compared   = 0;
    int mismatched = 0;

    localparam logic [6:0] Z  = 7'b0000000;  // idle
    localparam logic [6:0] FL = 7'b0000110;  // flush only
    localparam logic [6:0] HZ = 7'b1000000;  // decode hazard
    localparam logic [6:0] EX = 7'b1110000;  // execute busy
    localparam logic [6:0] MB = 7'b1111000;  // memory busy
    localparam logic [6:0] MP = 7'b1111001;  // memory busy, mispredict pending
    localparam logic [6:0] RP = 7'b0000111;  // replayed flush, pending still shown
    localparam logic [6:0] FX = 7'b0010110;  // flush over execute busy
    localparam logic [6:0] FM = 7'b0011110;  // flush over memory busy

    pipeline_controller #(.FLUSH_CYCLES(1)) u_dut1 (
        .clk_i                   (clk),
        .rst_i                   (rst_i),
        .en_stall_decode_stage_i (en_stall),
        .exe_busy_i              (exe_busy),
        .mem_busy_i              (mem_busy),
        .branch_mispredict_i     (mispredict),
        .stall_fetch_o           (o1[6]),
        .stall_decode_stage_o    (o1[5]),
        .stall_execute_o         (o1[4]),
        .stall_memory_o          (o1[3]),
        .flush_fetch_o           (o1[2]),
        .flush_decode_stage_o    (o1[1]),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cycles_o     (ps1),
        .perf_flush_count_o      (pf1),
`endif
        .flush_pending_o         (o1[0])
    );

    pipeline_controller #(.FLUSH_CYCLES(2)) u_dut2 (
        .clk_i                   (clk),
        .rst_i                   (rst_i),
        .en_stall_decode_stage_i (en_stall),
        .exe_busy_i              (exe_busy),
        .mem_busy_i              (mem_busy),
        .branch_mispredict_i     (mispredict),
        .stall_fetch_o           (o2[6]),
        .stall_decode_stage_o    (o2[5]),
        .stall_execute_o         (o2[4]),
        .stall_memory_o          (o2[3]),
        .flush_fetch_o           (o2[2]),
        .flush_decode_stage_o    (o2[1]),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cycles_o     (ps2),
        .perf_flush_count_o      (pf2),
`endif
        .flush_pending_o         (o2[0])
    );

    pipeline_controller #(.FLUSH_CYCLES(3)) u_dut3 (
        .clk_i                   (clk),
        .rst_i                   (rst_i),
        .en_stall_decode_stage_i (en_stall),
        .exe_busy_i              (exe_busy),
        .mem_busy_i              (mem_busy),
        .branch_mispredict_i     (mispredict),
        .stall_fetch_o           (o3[6]),
        .stall_decode_stage_o    (o3[5]),
        .stall_execute_o         (o3[4]),
        .stall_memory_o          (o3[3]),
        .flush_fetch_o           (o3[2]),
        .flush_decode_stage_o    (o3[1]),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cycles_o     (ps3),
        .perf_flush_count_o      (pf3),
`endif
        .flush_pending_o         (o3[0])
    );

    task automatic drive(input logic en, input logic exe, input logic mem, input logic mp);
        en_stall   = en;
        exe_busy   = exe;
        mem_busy   = mem;
        mispredict = mp;
    endtask

    // Reset: flush asserted while held; after release each instance flushes
    // for exactly FLUSH_CYCLES cycles.
    task automatic test_reset();
        logic [6:0] e1, e2, e3;
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b0;
        #1;
        compared++;
        if ({o1, o2, o3} !== {FL, FL, FL}) begin
            mismatched++;
            $display("FAIL reset_hold: got %b_%b_%b want %b_%b_%b", o1, o2, o3, FL, FL, FL);
        end
        @(negedge clk);
        rst_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            e1 = (c < 1) ? FL : Z;
            e2 = (c < 2) ? FL : Z;
            e3 = (c < 3) ? FL : Z;
            compared++;
            if ({o1, o2, o3} !== {e1, e2, e3}) begin
                mismatched++;
                $display("FAIL reset_release c%0d: got %b_%b_%b want %b_%b_%b", c, o1, o2, o3, e1, e2, e3);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_decode_hazard();
        logic [6:0] e;
        for (int c = 0; c < 4; c++) begin
            drive(c < 3, 1'b0, 1'b0, 1'b0);
            #1;
            e = (c < 3) ? HZ : Z;
            compared++;
            if ({o1, o2, o3} !== {e, e, e}) begin
                mismatched++;
                $display("FAIL decode_hazard c%0d: got %b_%b_%b want %b", c, o1, o2, o3, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_exe_busy();
        logic [6:0] e;
        for (int c = 0; c < 5; c++) begin
            drive(c < 4, c < 4, 1'b0, 1'b0);
            #1;
            e = (c < 4) ? EX : Z;
            compared++;
            if ({o1, o2, o3} !== {e, e, e}) begin
                mismatched++;
                $display("FAIL exe_busy c%0d: got %b_%b_%b want %b", c, o1, o2, o3, e);
            end
            @(negedge clk);
        end
    endtask

    // Memory busy cycles 0-5, mispredict held 2-5: pending 3-5, flush
    // replayed in cycle 6, then FLUSH_CYCLES-1 further flush cycles.
    task automatic test_mem_defer();
        logic [6:0] e1, e2, e3;
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 1'b0, c <= 5, (c >= 2) && (c <= 5));
            #1;
            case (c)
                0, 1, 2: begin e1 = MB; e2 = MB; e3 = MB; end
                3, 4, 5: begin e1 = MP; e2 = MP; e3 = MP; end
                6:       begin e1 = RP; e2 = RP; e3 = RP; end
                7:       begin e1 = Z;  e2 = FL; e3 = FL; end
                8:       begin e1 = Z;  e2 = Z;  e3 = FL; end
                default: begin e1 = Z;  e2 = Z;  e3 = Z;  end
            endcase
            compared++;
            if ({o1, o2, o3} !== {e1, e2, e3}) begin
                mismatched++;
                $display("FAIL mem_defer c%0d: got %b_%b_%b want %b_%b_%b", c, o1, o2, o3, e1, e2, e3);
            end
            @(negedge clk);
        end
    endtask

    // Mispredict arriving as memory releases is flushed at once, not deferred.
    task automatic test_mispredict_mem_fall();
        logic [6:0] e1, e2, e3;
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b0, c == 0, c == 1);
            #1;
            case (c)
                0:       begin e1 = MB; e2 = MB; e3 = MB; end
                1:       begin e1 = FL; e2 = FL; e3 = FL; end
                2:       begin e1 = Z;  e2 = FL; e3 = FL; end
                3:       begin e1 = Z;  e2 = Z;  e3 = FL; end
                default: begin e1 = Z;  e2 = Z;  e3 = Z;  end
            endcase
            compared++;
            if ({o1, o2, o3} !== {e1, e2, e3}) begin
                mismatched++;
                $display("FAIL mem_fall c%0d: got %b_%b_%b want %b_%b_%b", c, o1, o2, o3, e1, e2, e3);
            end
            @(negedge clk);
        end
    endtask

    // Pulses in cycles 0 and 2. The second pulse is a new flush for
    // FLUSH_CYCLES 1 and 2 (back in RUN) but ignored inside the 3-cycle window.
    task automatic test_mispredict_pulse();
        logic [6:0] e1, e2, e3;
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'b0, 1'b0, (c == 0) || (c == 2));
            #1;
            case (c)
                0:       begin e1 = FL; e2 = FL; e3 = FL; end
                1:       begin e1 = Z;  e2 = FL; e3 = FL; end
                2:       begin e1 = FL; e2 = FL; e3 = FL; end
                3:       begin e1 = Z;  e2 = FL; e3 = Z;  end
                default: begin e1 = Z;  e2 = Z;  e3 = Z;  end
            endcase
            compared++;
            if ({o1, o2, o3} !== {e1, e2, e3}) begin
                mismatched++;
                $display("FAIL mispredict_pulse c%0d: got %b_%b_%b want %b_%b_%b", c, o1, o2, o3, e1, e2, e3);
            end
            @(negedge clk);
        end
    endtask

    // Flush overrides fetch/decode stalls; execute/memory still stall; a
    // memory wait does not pause the flush counter.
    task automatic test_flush_override();
        logic [6:0] e1, e2, e3;
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, c == 0, c == 1, c == 0);
            #1;
            case (c)
                0:       begin e1 = FX; e2 = FX; e3 = FX; end
                1:       begin e1 = MB; e2 = FM; e3 = FM; end
                2:       begin e1 = Z;  e2 = Z;  e3 = FL; end
                default: begin e1 = Z;  e2 = Z;  e3 = Z;  end
            endcase
            compared++;
            if ({o1, o2, o3} !== {e1, e2, e3}) begin
                mismatched++;
                $display("FAIL flush_override c%0d: got %b_%b_%b want %b_%b_%b", c, o1, o2, o3, e1, e2, e3);
            end
            @(negedge clk);
        end
    endtask

    // Reset during MEM_HOLD drops the pending mispredict immediately; only
    // the reset flush follows release.
    task automatic test_reset_mid_hold();
        logic [6:0] e1, e2, e3;
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        compared++;
        if ({o1, o2, o3} !== {MB, MB, MB}) begin
            mismatched++;
            $display("FAIL hold_enter: got %b_%b_%b want %b", o1, o2, o3, MB);
        end
        @(negedge clk);
        #1;
        compared++;
        if ({o1, o2, o3} !== {MP, MP, MP}) begin
            mismatched++;
            $display("FAIL hold_pending: got %b_%b_%b want %b", o1, o2, o3, MP);
        end
        #2;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b0;
        #1;
        compared++;
        if ({o1, o2, o3} !== {FL, FL, FL}) begin
            mismatched++;
            $display("FAIL hold_reset: got %b_%b_%b want %b", o1, o2, o3, FL);
        end
        @(negedge clk);
        rst_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            e1 = (c < 1) ? FL : Z;
            e2 = (c < 2) ? FL : Z;
            e3 = (c < 3) ? FL : Z;
            compared++;
            if ({o1, o2, o3} !== {e1, e2, e3}) begin
                mismatched++;
                $display("FAIL hold_release c%0d: got %b_%b_%b want %b_%b_%b", c, o1, o2, o3, e1, e2, e3);
            end
            @(negedge clk);
        end
    endtask

`ifdef PIPE_CTRL_PERF_EN
    // Counters start at zero after the preceding reset. Cycle plan:
    // 0 mispredict, 2 mispredict+mem (deferred), 3 mem held, 4 replay,
    // 5 mispredict. FLUSH_CYCLES=1 accepts 3; FLUSH_CYCLES=2 accepts 2
    // (cycle 5 lands in its flush window). Both see 2 fetch-stall cycles.
    task automatic test_perf();
        for (int c = 0; c < 7; c++) begin
            drive(1'b0, 1'b0, (c == 2) || (c == 3), (c == 0) || (c == 2) || (c == 3) || (c == 5));
            @(negedge clk);
        end
        #1;
        compared++;
        if (pf1 !== 16'd3) begin
            mismatched++;
            $display("FAIL perf_flush_n1: got %0d want 3", pf1);
        end
        compared++;
        if (pf2 !== 16'd2) begin
            mismatched++;
            $display("FAIL perf_flush_n2: got %0d want 2", pf2);
        end
        compared++;
        if ({ps1, ps2} !== {32'd2, 32'd2}) begin
            mismatched++;
            $display("FAIL perf_stall: got %0d/%0d want 2/2", ps1, ps2);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_decode_hazard();
        test_exe_busy();
        test_mem_defer();
        test_mispredict_mem_fall();
        test_mispredict_pulse();
        test_flush_override();
        test_reset_mid_hold();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
